fir_mac_filter: RTL and testbench
=================================

# fir_mac_filter

Parametrised serial-MAC FIR filter that replaces the fixed low-pass filter core between the DDS tone generator and the DA output stage. It runs on the system clock, accepts offset-binary samples on a valid/ready strobe (sample rate set by the upstream strobe rather than a dedicated PLL clock), and computes one output per input using a single time-shared multiplier. It also provides run-time coefficient loading, rounding, and selectable saturation. Its output drives the DA data input directly.

## Interface
- DATA_W, 8: input sample width, offset-binary.
- COEF_W, 12: coefficient width, signed two's complement.
- TAPS, 32: filter length, 2..256.
- SHIFT, 10: accumulator right-shift, i.e. coefficient fraction bits.
- OUT_W, 8: output width, offset-binary.
- CLK  in  1  system clock.
- RSTn  in  1  reset; synchronous, active-low.
- in_valid  in  1  sample strobe.
- in_data  in  DATA_W  input sample (0x80 = zero for DATA_W=8).
- in_ready  out  1  block can accept a sample.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  clog2(TAPS)  tap index k.
- coef_data  in  COEF_W  coefficient value.
- coef_drop  out  1  one-cycle pulse: write was ignored because busy.
- out_valid  out  1  one-cycle pulse: new out_data.
- out_data  out  OUT_W  filtered sample, offset-binary, held between pulses.
- sat  out  1  qualified by out_valid: result was clipped.

## Operation
- Input conversion: signed x = in_data with the MSB inverted. Output conversion is the same MSB inversion.
- Delay line: circular buffer of TAPS signed samples with a write pointer. An accepted sample is written at wr_ptr. x[n-k] is read from (wr_ptr - k) mod TAPS; the wrap-around must be exact for non-power-of-two TAPS.
- FSM states:
  - IDLE: in_ready=1. On in_valid go to MAC.
  - MAC: TAPS cycles, k = 0..TAPS-1, acc += x[n-k]*coef[k]. Then go to ROUND.
  - ROUND: result = (acc + 2^(SHIFT-1)) >>> SHIFT, reduced to OUT_W, registered into out_data with out_valid=1. Then go to IDLE.
- ACC_W = DATA_W + COEF_W + clog2(TAPS). The accumulator must never overflow internally.
- Coefficient writes:
  - Honoured only in IDLE; the write takes effect at that edge.
  - A write in the same cycle as an accepted sample is used by that sample's MAC.
  - A write in MAC or ROUND is discarded and coef_drop pulses.
- Reset values:
  - in_ready=0 while RSTn is low.
  - out_valid=0, out_data = mid-scale (0x80), sat=0, coef_drop=0.
  - Delay line all zero; wr_ptr=0; FSM in IDLE.
  - Coefficients: coef[0] = 2^SHIFT (unit impulse, 1024 by default), all others 0.
- Reset mid-operation: MAC is aborted, no out_valid is produced for the aborted sample, and all state returns to the reset values above.
- in_valid while in_ready=0: the sample is not consumed; upstream must hold it or drop it.

## Timing
- Sample accepted at edge E0 (in_valid & in_ready).
- out_valid and new out_data are visible after edge E0+TAPS+2.
- in_ready is low for TAPS+1 cycles and high again in the same cycle as out_valid.
- Maximum throughput: one sample per TAPS+2 cycles.
- The multiplier may be registered, provided the E0+TAPS+2 latency is preserved.
- in_ready is registered. All outputs come from registers.

## Configuration
- FIR_SAT_EN defined:
  - A result outside the signed OUT_W range is clamped to max (0xFF) or min (0x00) in offset-binary.
  - sat=1 with that out_valid.
- FIR_SAT_EN undefined:
  - The low OUT_W bits of the result are kept (two's-complement wrap).
  - sat is tied to 0.

## Structure
- Package fir_pkg holds:
  - state enum {IDLE, MAC, ROUND};
  - function acc_width(DATA_W, COEF_W, TAPS);
  - function midscale(W);
  - localparam defaults for coefficient reset.
- Sub-module fir_coef_ram: TAPS×COEF_W register file with impulse reset, one synchronous write port and one read port indexed by k.

## Test plan
- Default impulse: after reset out_data=0x80. Push 0xC0 → at E0+34 out_valid=1, out_data=0xC0, sat=0.
- Moving average: load coef[0..3]=256, rest 0, then push 0xC0 five times → outputs 0x90, 0xA0, 0xB0, 0xC0, 0xC0.
- Saturation: coef[0]=coef[1]=2047, push 0xFF twice.
  - With FIR_SAT_EN: second output 0xFF, sat=1.
  - Without FIR_SAT_EN: second output 0x7C, sat=0.
- Handshake: in_valid held high for 200 cycles → exactly one accept every 34 cycles; in_ready low for 33 cycles after each accept.
- Busy write: coef_we (addr 0, data 0) issued during MAC → coef_drop pulse; the next output still equals the impulse-response value.
- Mid-MAC reset: RSTn low for one cycle at E0+10 → no out_valid, out_data=0x80. The next 0xC0 yields 0xC0, proving the delay line was cleared.

Source files
------------

// File: rtl/fir_mac_filter_pkg.sv
// rtl/fir_mac_filter_pkg.sv - shared FSM type, width helpers and coefficient reset defaults for fir_mac_filter
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        ROUND = 2'd2
    } fir_state_e;

    // Coefficient reset: a unit impulse of 2^SHIFT on tap 0, all other taps zero.
    localparam int unsigned COEF_RST_TAP   = 0;
    localparam int          COEF_RST_SHIFT = 10;

    function automatic int acc_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

    function automatic logic [31:0] midscale(input int w);
        return 32'd1 << (w - 1);
    endfunction

    function automatic logic [31:0] impulse(input int shift);
        return 32'd1 << shift;
    endfunction

endpackage

// File: rtl/fir_mac_filter_if.sv
// rtl/fir_mac_filter_if.sv - sample, coefficient and result signals of fir_mac_filter
interface fir_mac_filter_if #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 12,
    parameter int TAPS   = 32,
    parameter int OUT_W  = 8
) ();
    localparam int AW = $clog2(TAPS);

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              coef_we;
    logic [AW-1:0]     coef_addr;
    logic [COEF_W-1:0] coef_data;
    logic              coef_drop;
    logic              out_valid;
    logic [OUT_W-1:0]  out_data;
    logic              sat;

    modport master (
        output in_valid, in_data, coef_we, coef_addr, coef_data,
        input  in_ready, coef_drop, out_valid, out_data, sat
    );

    modport slave (
        input  in_valid, in_data, coef_we, coef_addr, coef_data,
        output in_ready, coef_drop, out_valid, out_data, sat
    );

endinterface

// File: rtl/fir_mac_filter_coef_ram.sv
// rtl/fir_mac_filter_coef_ram.sv - TAPS x COEF_W coefficient register file, unit-impulse reset
module fir_coef_ram
    import fir_pkg::*;
#(
    parameter int COEF_W = 12,
    parameter int TAPS   = 32,
    parameter int SHIFT  = COEF_RST_SHIFT,
    parameter int AW     = $clog2(TAPS)
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [COEF_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [COEF_W-1:0] rdata_o
);
    localparam logic [COEF_W-1:0] UNIT = COEF_W'(impulse(SHIFT));

    logic [COEF_W-1:0] mem_q [TAPS];

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < TAPS; i++) begin
                mem_q[i] <= (i == COEF_RST_TAP) ? UNIT : '0;
            end
        end else if (we_i && (int'(waddr_i) < TAPS)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fir_mac_filter.sv
// rtl/fir_mac_filter.sv - serial-MAC FIR filter, one shared multiplier; FIR_SAT_EN selects clamping over wrap
module fir_mac_filter
    import fir_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int COEF_W = 12,
    parameter int TAPS   = 32,
    parameter int SHIFT  = COEF_RST_SHIFT,
    parameter int OUT_W  = 8
) (
    input  logic            CLK,
    input  logic            RSTn,
    fir_mac_filter_if.slave bus
);
    localparam int AW    = $clog2(TAPS);
    localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
    localparam int PW    = DATA_W + COEF_W;
    localparam int RW    = ACC_W + 1 - SHIFT;
    localparam logic [AW-1:0]    LAST     = AW'(TAPS - 1);
    localparam logic [OUT_W-1:0] MID      = OUT_W'(midscale(OUT_W));
    localparam logic [ACC_W:0]   RND_BIAS = (ACC_W + 1)'(impulse(SHIFT - 1));

    fir_state_e               state_q, state_d;
    logic [AW-1:0]            k_q, k_d;
    logic [AW-1:0]            rd_q, rd_d;
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     in_ready_q, in_ready_d;
    logic                     out_valid_q, out_valid_d;
    logic [OUT_W-1:0]         out_data_q, out_data_d;
    logic                     sat_q, sat_d;
    logic                     coef_drop_q, coef_drop_d;
    logic signed [DATA_W-1:0] dl_q [TAPS];

    logic                     accept, dl_we, coef_wr;
    logic signed [DATA_W-1:0] x_in, x_rd;
    logic [COEF_W-1:0]        coef_raw;
    logic signed [COEF_W-1:0] coef_rd;
    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic [ACC_W:0]           rnd;
    logic [RW-1:0]            res;
    logic [OUT_W-1:0]         res_out;
    logic                     res_sat;
    logic                     unused_rnd;

    assign accept  = bus.in_valid && in_ready_q;
    assign coef_wr = bus.coef_we && (state_q == IDLE);
    assign x_in    = {~bus.in_data[DATA_W-1], bus.in_data[DATA_W-2:0]};

    fir_coef_ram #(
        .COEF_W (COEF_W),
        .TAPS   (TAPS),
        .SHIFT  (SHIFT),
        .AW     (AW)
    ) u_coef (
        .clk_i   (CLK),
        .rstn_i  (RSTn),
        .we_i    (coef_wr),
        .waddr_i (bus.coef_addr),
        .wdata_i (bus.coef_data),
        .raddr_i (k_q),
        .rdata_o (coef_raw)
    );

    assign coef_rd  = coef_raw;
    assign x_rd     = dl_q[rd_q];
    assign prod     = x_rd * coef_rd;
    assign prod_ext = {{(ACC_W - PW){prod[PW-1]}}, prod};

    // Round half up, then arithmetic shift: taking the upper slice is the >>> SHIFT.
    assign rnd = {acc_q[ACC_W-1], acc_q} + RND_BIAS;
    assign res = rnd[ACC_W:SHIFT];

`ifdef FIR_SAT_EN
    logic [RW-OUT_W:0] res_hi;
    logic              pos_ovf, neg_ovf;

    assign res_hi  = res[RW-1:OUT_W-1];
    assign pos_ovf = !res[RW-1] && (|res_hi);
    assign neg_ovf =  res[RW-1] && !(&res_hi);

    always_comb begin
        res_out = {~res[OUT_W-1], res[OUT_W-2:0]};
        res_sat = pos_ovf || neg_ovf;
        if (pos_ovf) begin
            res_out = '1;
        end else if (neg_ovf) begin
            res_out = '0;
        end
    end

    assign unused_rnd = ^rnd[SHIFT-1:0];
`else
    assign res_out    = {~res[OUT_W-1], res[OUT_W-2:0]};
    assign res_sat    = 1'b0;
    assign unused_rnd = ^{rnd[SHIFT-1:0], res[RW-1:OUT_W]};
`endif

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        rd_d        = rd_q;
        wr_ptr_d    = wr_ptr_q;
        acc_d       = acc_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        sat_d       = sat_q;
        dl_we       = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = MAC;
                    k_d      = '0;
                    rd_d     = wr_ptr_q;
                    wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + AW'(1);
                    acc_d    = '0;
                    dl_we    = 1'b1;
                end
            end
            MAC: begin
                // rd walks backwards from the newest sample with an explicit wrap,
                // so non-power-of-two TAPS index correctly.
                acc_d = acc_q + prod_ext;
                k_d   = k_q + AW'(1);
                rd_d  = (rd_q == '0) ? LAST : rd_q - AW'(1);
                if (k_q == LAST) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                state_d     = IDLE;
                out_valid_d = 1'b1;
                out_data_d  = res_out;
                sat_d       = res_sat;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        coef_drop_d = bus.coef_we && (state_q != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q     <= IDLE;
            k_q         <= '0;
            rd_q        <= '0;
            wr_ptr_q    <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= MID;
            sat_q       <= 1'b0;
            coef_drop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            rd_q        <= rd_d;
            wr_ptr_q    <= wr_ptr_d;
            acc_q       <= acc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            sat_q       <= sat_d;
            coef_drop_q <= coef_drop_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            for (int i = 0; i < TAPS; i++) begin
                dl_q[i] <= '0;
            end
        end else if (dl_we) begin
            dl_q[wr_ptr_q] <= x_in;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.sat       = sat_q;
    assign bus.coef_drop = coef_drop_q;

endmodule

// File: tb/tb_fir_mac_filter.sv
// tb/tb_fir_mac_filter.sv - self-checking bench for fir_mac_filter against an arithmetic reference model
module tb_fir_mac_filter;
    localparam int DATA_W = 8;
    localparam int COEF_W = 12;
    localparam int TAPS   = 32;
    localparam int SHIFT  = 10;
    localparam int OUT_W  = 8;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    fir_mac_filter_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W)) bus ();

    fir_mac_filter #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .TAPS   (TAPS),
        .SHIFT  (SHIFT),
        .OUT_W  (OUT_W)
    ) dut (
        .CLK  (clk),
        .RSTn (rstn),
        .bus  (bus)
    );

    initial forever #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: history of signed samples, coefficient table, transaction timing.
    int               cyc = 0;
    bit               armed = 0;
    bit               m_rdy, m_busy, m_ov, m_sat, m_drop, p_sat;
    logic [OUT_W-1:0] m_od, p_od;
    int               done_cyc, y_acc;
    int               coef_m [TAPS];
    int               hist   [TAPS];

    int acc_log[$];
    int ov_log[$];
    int od_log[$];
    int sat_log[$];
    int drop_cnt = 0;

    function automatic void expect_out(input int y, output logic [OUT_W-1:0] od, output bit s);
        int          r;
        logic [31:0] rb;
        r  = (y + (1 << (SHIFT - 1))) >>> SHIFT;
        rb = r;
        od = {~rb[OUT_W-1], rb[OUT_W-2:0]};
        s  = 1'b0;
`ifdef FIR_SAT_EN
        if (r > (2 ** (OUT_W - 1)) - 1) begin
            od = '1;
            s  = 1'b1;
        end else if (r < -(2 ** (OUT_W - 1))) begin
            od = '0;
            s  = 1'b1;
        end
`endif
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (bus.in_valid && bus.in_ready) acc_log.push_back(cyc);
        if (bus.out_valid) begin
            ov_log.push_back(cyc);
            od_log.push_back(int'(bus.out_data));
            sat_log.push_back(int'(bus.sat));
        end
        if (bus.coef_drop) drop_cnt++;
        armed = 1'b1;
        if (!rstn) begin
            m_rdy  = 1'b0;
            m_busy = 1'b0;
            m_ov   = 1'b0;
            m_od   = 8'h80;
            m_sat  = 1'b0;
            m_drop = 1'b0;
            foreach (coef_m[i]) coef_m[i] = (i == 0) ? (1 << SHIFT) : 0;
            foreach (hist[i]) hist[i] = 0;
        end else begin
            m_ov   = 1'b0;
            m_drop = 1'b0;
            if (m_busy) begin
                if (bus.coef_we) m_drop = 1'b1;
                if (cyc == done_cyc) begin
                    m_busy = 1'b0;
                    m_ov   = 1'b1;
                    m_od   = p_od;
                    m_sat  = p_sat;
                    m_rdy  = 1'b1;
                end
            end else begin
                if (bus.coef_we) coef_m[bus.coef_addr] = int'($signed(bus.coef_data));
                if (bus.in_valid && m_rdy) begin
                    for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
                    hist[0] = int'($signed(bus.in_data ^ 8'h80));
                    y_acc = 0;
                    for (int k = 0; k < TAPS; k++) y_acc += hist[k] * coef_m[k];
                    expect_out(y_acc, p_od, p_sat);
                    m_busy   = 1'b1;
                    done_cyc = cyc + TAPS + 1;
                    m_rdy    = 1'b0;
                end else begin
                    m_rdy = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("in_ready", bus.in_ready, m_rdy);
            chk("out_valid", bus.out_valid, m_ov);
            chk("out_data", bus.out_data, m_od);
            chk("coef_drop", bus.coef_drop, m_drop);
            if (m_ov) chk("sat", bus.sat, m_sat);
        end
    end

    function automatic int od_at(input int i);
        return (i < od_log.size()) ? od_log[i] : -1;
    endfunction

    function automatic int sat_at(input int i);
        return (i < sat_log.size()) ? sat_log[i] : -1;
    endfunction

    function automatic int acc_at(input int i);
        return (i < acc_log.size()) ? acc_log[i] : -100000;
    endfunction

    function automatic int ov_at(input int i);
        return (i < ov_log.size()) ? ov_log[i] : 100000;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        acc_log.delete();
        ov_log.delete();
        od_log.delete();
        sat_log.delete();
        drop_cnt = 0;
    endtask

    task automatic push(input logic [DATA_W-1:0] v);
        int n = 0;
        while (!bus.in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) chk("push_timeout", 0, 1);
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic write_coef(input int addr, input int data);
        bus.coef_we   = 1'b1;
        bus.coef_addr = 5'(addr);
        bus.coef_data = 12'(data);
        @(negedge clk);
        bus.coef_we   = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int t = 0;
        while (od_log.size() < n && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (od_log.size() < n) chk("wait_out_timeout", od_log.size(), n);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h80;
        bus.coef_we   = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;

        // Default impulse response and latency
        do_reset();
        chk("rst_out_data", bus.out_data, 8'h80);
        chk("rst_in_ready_after_release", bus.in_ready, 1);
        push(8'hC0);
        wait_out(1);
        chk("impulse_data", od_at(0), 8'hC0);
        chk("impulse_sat", sat_at(0), 0);
        chk("impulse_latency", ov_at(0) - acc_at(0), TAPS + 2);

        // Four-tap moving average
        do_reset();
        for (int i = 0; i < 4; i++) write_coef(i, 256);
        repeat (5) push(8'hC0);
        wait_out(5);
        chk("mavg_0", od_at(0), 8'h90);
        chk("mavg_1", od_at(1), 8'hA0);
        chk("mavg_2", od_at(2), 8'hB0);
        chk("mavg_3", od_at(3), 8'hC0);
        chk("mavg_4", od_at(4), 8'hC0);

        // Large positive result: clamp or wrap
        do_reset();
        write_coef(0, 2047);
        write_coef(1, 2047);
        push(8'hFF);
        push(8'hFF);
        wait_out(2);
`ifdef FIR_SAT_EN
        chk("satbig_0_data", od_at(0), 8'hFF);
        chk("satbig_0_sat", sat_at(0), 1);
        chk("satbig_1_data", od_at(1), 8'hFF);
        chk("satbig_1_sat", sat_at(1), 1);
`else
        chk("satbig_0_data", od_at(0), 8'h7E);
        chk("satbig_0_sat", sat_at(0), 0);
        chk("satbig_1_data", od_at(1), 8'h7C);
        chk("satbig_1_sat", sat_at(1), 0);
`endif

        // in_valid held high: one accept per TAPS+2 cycles
        do_reset();
        bus.in_data  = 8'h80;
        bus.in_valid = 1'b1;
        repeat (200) @(negedge clk);
        bus.in_valid = 1'b0;
        wait_out(6);
        chk("hs_accepts", acc_log.size(), 6);
        for (int i = 1; i < 6; i++) chk("hs_gap", acc_at(i) - acc_at(i-1), TAPS + 2);

        // Coefficient write while busy is dropped
        do_reset();
        push(8'hC0);
        repeat (5) @(negedge clk);
        write_coef(0, 0);
        wait_out(1);
        chk("busy_wr_data", od_at(0), 8'hC0);
        chk("busy_wr_drops", drop_cnt, 1);
        push(8'hC0);
        wait_out(2);
        chk("busy_wr_coef_kept", od_at(1), 8'hC0);

        // Reset ten cycles into MAC aborts the sample and clears the delay line
        do_reset();
        push(8'hC0);
        repeat (9) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (50) @(negedge clk);
        chk("abort_no_out", ov_log.size(), 0);
        chk("abort_out_data", bus.out_data, 8'h80);
        write_coef(1, 1024);
        push(8'hC0);
        wait_out(1);
        chk("abort_dl_cleared", od_at(0), 8'hC0);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
